// File: rtl/fp_add_pkg.sv
// -----------------------------------------------------------------------------
// fp_add_pkg
//   Shared constants, types and helpers for the floating-point adder
//   align-and-add datapath.
//   - GRS_W       : number of guard/round/sticky bits appended below the LSB
//   - MAX_FRAC_W  : widest significand the sticky helper supports
//   - ext_width() : significand width once extended with GRS bits
//   - align_ctl_t : sign/operation control carried with the aligned operands
//   - sticky_shr(): OR of every bit a right shift by 'sh' discards
// -----------------------------------------------------------------------------
package fp_add_pkg;

    localparam int GRS_W      = 3;
    localparam int MAX_FRAC_W = 64;
    localparam int MAX_EXT_W  = MAX_FRAC_W + GRS_W;

    // Control carried alongside the aligned magnitudes into the add stage.
    typedef struct packed {
        logic sign_a;   // sign of A
        logic eb;       // effective sign of B (sign_b ^ symbol)
        logic eff_sub;  // magnitudes are subtracted
    } align_ctl_t;

    function automatic int ext_width(input int frac_w);
        return frac_w + GRS_W;
    endfunction

    // Sticky of a right shift: any 1 among the 'sh' lowest bits of v.
    // A shift wider than v covers every bit, so sticky becomes |v.
    function automatic logic sticky_shr(input logic [MAX_EXT_W-1:0] v,
                                        input logic [31:0]          sh);
        logic s;
        s = 1'b0;
        for (int unsigned i = 0; i < MAX_EXT_W; i++) begin
            if (i < sh) s = s | v[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// -----------------------------------------------------------------------------
// fp_align_shifter
//   Combinational barrel right shift used to align the smaller-exponent
//   operand. Reports the OR of every bit shifted out below the LSB.
//   Supports EXT_W <= MAX_EXT_W and shift amounts below 2**32.
//   Ports:
//     value   in  EXT_W  operand, already extended with GRS bits
//     shamt   in  EXP_W  right-shift distance (exponent difference)
//     shifted out EXT_W  value >> shamt (0 once shamt >= EXT_W)
//     sticky  out 1      OR of all discarded bits
// -----------------------------------------------------------------------------
module fp_align_shifter
    import fp_add_pkg::*;
#(
    parameter int EXT_W = 27,
    parameter int EXP_W = 8
) (
    input  logic [EXT_W-1:0] value,
    input  logic [EXP_W-1:0] shamt,
    output logic [EXT_W-1:0] shifted,
    output logic             sticky
);

    assign shifted = value >> shamt;
    assign sticky  = sticky_shr(MAX_EXT_W'(value), 32'(shamt));

endmodule

// File: rtl/fp_align_add_pipe.sv
// -----------------------------------------------------------------------------
// fp_align_add_pipe
//   Three-stage valid/ready significand align-and-add stage of an IEEE-754
//   adder. S1 aligns the smaller-exponent operand (GRS capture), S2 compares
//   and adds/subtracts magnitudes, S3 registers the unnormalised result.
//   Parameters:
//     FRAC_W  significand width incl. hidden bit (<= 64)
//     EXP_W   width of the exponent-difference input
//     ADDER   0 = ripple-carry, 1 = carry-lookahead (bit-identical results)
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     in_valid/in_ready   operand handshake
//     frac_a, frac_b      significands A and B
//     diff_exp            |expA - expB|
//     sign_exp            0: shift B, 1: shift A
//     sign_a, sign_b      operand signs
//     symbol              0: A+B, 1: A-B
//     out_valid/out_ready result handshake
//     out                 magnitude incl. carry-out bit (FRAC_W+1)
//     grs                 guard, round, sticky
//     sign_out            result sign
//     zero                out and grs are all zero
// -----------------------------------------------------------------------------
module fp_align_add_pipe
    import fp_add_pkg::*;
#(
    parameter int FRAC_W = 24,
    parameter int EXP_W  = 8,
    parameter int ADDER  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] frac_a,
    input  logic [FRAC_W-1:0] frac_b,
    input  logic [EXP_W-1:0]  diff_exp,
    input  logic              sign_exp,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic              symbol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W:0]   out,
    output logic [2:0]        grs,
    output logic              sign_out,
    output logic              zero
);

    localparam int EXT_W = ext_width(FRAC_W);
    localparam int RES_W = EXT_W + 1;

    typedef struct packed {
        logic [EXT_W-1:0] mag_a;
        logic [EXT_W-1:0] mag_b;
        align_ctl_t       ctl;
    } s1_t;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             sign;
        logic             zero;
    } s2_t;

    // ---------------------------------------------------------------- handshake
    logic s1_v, s2_v, s3_v;
    logic s1_rdy, s2_rdy, s3_rdy;

    // A stage may load when it is empty or its content moves on this edge.
    assign s3_rdy    = !s3_v || out_ready;
    assign s2_rdy    = !s2_v || s3_rdy;
    assign s1_rdy    = !s1_v || s2_rdy;
    assign in_ready  = s1_rdy;
    assign out_valid = s3_v;

    // ---------------------------------------------------------------- S1 align
    logic [EXT_W-1:0] ext_a, ext_b, to_shift, shifted;
    logic             sticky;
    s1_t              s1_d, s1_q;

    assign ext_a    = {frac_a, {GRS_W{1'b0}}};
    assign ext_b    = {frac_b, {GRS_W{1'b0}}};
    assign to_shift = sign_exp ? ext_a : ext_b;

    fp_align_shifter #(
        .EXT_W (EXT_W),
        .EXP_W (EXP_W)
    ) u_shifter (
        .value   (to_shift),
        .shamt   (diff_exp),
        .shifted (shifted),
        .sticky  (sticky)
    );

    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        logic [EXT_W-1:0] aligned;
        s1_d        = '0;
        aligned     = shifted | EXT_W'(sticky);
        s1_d.mag_a  = sign_exp ? aligned : ext_a;
        s1_d.mag_b  = sign_exp ? ext_b : aligned;
        s1_d.ctl.sign_a  = sign_a;
        s1_d.ctl.eb      = sign_b ^ symbol;
        s1_d.ctl.eff_sub = sign_a ^ (sign_b ^ symbol);
    end

    // ---------------------------------------------------------------- S2 add
    logic             a_ge_b;
    logic [EXT_W-1:0] add_x, add_y, add_sum;
    logic             add_cin, add_cout;
    s2_t              s2_d, s2_q;

    // Subtraction is big + ~small + 1, so the result is never negative.
    always_comb begin
        a_ge_b  = (s1_q.mag_a >= s1_q.mag_b);
        add_x   = s1_q.mag_a;
        add_y   = s1_q.mag_b;
        add_cin = 1'b0;
        if (s1_q.ctl.eff_sub) begin
            add_x   = a_ge_b ? s1_q.mag_a : s1_q.mag_b;
            add_y   = ~(a_ge_b ? s1_q.mag_b : s1_q.mag_a);
            add_cin = 1'b1;
        end
    end

    generate
        if (ADDER == 0) begin : g_ripple
            always_comb begin : chain
                logic c;
                c       = add_cin;
                add_sum = '0;
                for (int i = 0; i < EXT_W; i++) begin
                    add_sum[i] = add_x[i] ^ add_y[i] ^ c;
                    c = (add_x[i] & add_y[i]) | (c & (add_x[i] ^ add_y[i]));
                end
                add_cout = c;
            end
        end else begin : g_lookahead
            localparam int LVL = $clog2(EXT_W);
            // Kogge-Stone prefix: after LVL levels g[i] is the carry out of bit i.
            always_comb begin : prefix
                logic [EXT_W-1:0] p0, g, p, gn, pn;
                p0   = add_x ^ add_y;
                g    = add_x & add_y;
                g[0] = g[0] | (p0[0] & add_cin);
                p    = p0;
                for (int l = 0; l < LVL; l++) begin
                    gn = g;
                    pn = p;
                    for (int i = (1 << l); i < EXT_W; i++) begin
                        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                        pn[i] = p[i] & p[i - (1 << l)];
                    end
                    g = gn;
                    p = pn;
                end
                add_sum  = p0 ^ {g[EXT_W-2:0], add_cin};
                add_cout = g[EXT_W-1];
            end
        end
    endgenerate

    always_comb begin
        s2_d        = '0;
        s2_d.result = s1_q.ctl.eff_sub ? {1'b0, add_sum} : {add_cout, add_sum};
        s2_d.zero   = (s2_d.result == '0);
        if (!s1_q.ctl.eff_sub)
            s2_d.sign = s1_q.ctl.sign_a;
        else if (s2_d.zero)
            s2_d.sign = 1'b0;          // exact cancellation gives +0
        else
            s2_d.sign = a_ge_b ? s1_q.ctl.sign_a : s1_q.ctl.eb;
    end

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: payload registers are reset along with the valids so the outputs
    // read as zero after reset, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_q <= '0;
            s2_v <= 1'b0;
            s2_q <= '0;
            s3_v <= 1'b0;
            out      <= '0;
            grs      <= '0;
            sign_out <= 1'b0;
            zero     <= 1'b0;
        end else begin
            if (s1_rdy) begin
                s1_v <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_rdy) begin
                s2_v <= s1_v;
                if (s1_v) s2_q <= s2_d;
            end
            // Output fields only change when S3 loads, so they hold under stall.
            if (s3_rdy) begin
                s3_v <= s2_v;
                if (s2_v) begin
                    out      <= s2_q.result[RES_W-1:GRS_W];
                    grs      <= s2_q.result[GRS_W-1:0];
                    sign_out <= s2_q.sign;
                    zero     <= s2_q.zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_align_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_align_add_pipe
//   Drives a ripple-carry and a carry-lookahead instance with identical
//   stimulus and scoreboards both against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_align_add_pipe;

    localparam int FW = 24;
    localparam int EW = 8;
    localparam int XW = FW + 3;

    typedef struct packed {
        logic [FW:0] out;
        logic [2:0]  grs;
        logic        sign;
        logic        zero;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, out_ready;
    logic [FW-1:0] frac_a, frac_b;
    logic [EW-1:0] diff_exp;
    logic          sign_exp, sign_a, sign_b, symbol;

    logic          ir_rc, ov_rc, sign_rc, zero_rc;
    logic [FW:0]   out_rc;
    logic [2:0]    grs_rc;
    logic          ir_la, ov_la, sign_la, zero_la;
    logic [FW:0]   out_la;
    logic [2:0]    grs_la;

    always #5 clk = ~clk;

    fp_align_add_pipe #(.FRAC_W(FW), .EXP_W(EW), .ADDER(0)) u_rc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_rc),
        .frac_a(frac_a), .frac_b(frac_b), .diff_exp(diff_exp), .sign_exp(sign_exp),
        .sign_a(sign_a), .sign_b(sign_b), .symbol(symbol),
        .out_valid(ov_rc), .out_ready(out_ready), .out(out_rc), .grs(grs_rc),
        .sign_out(sign_rc), .zero(zero_rc)
    );

    fp_align_add_pipe #(.FRAC_W(FW), .EXP_W(EW), .ADDER(1)) u_la (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_la),
        .frac_a(frac_a), .frac_b(frac_b), .diff_exp(diff_exp), .sign_exp(sign_exp),
        .sign_a(sign_a), .sign_b(sign_b), .symbol(symbol),
        .out_valid(ov_la), .out_ready(out_ready), .out(out_la), .grs(grs_la),
        .sign_out(sign_la), .zero(zero_la)
    );

    int    checks   = 0;
    int    failures = 0;
    exp_t  q[$];
    bit    use_const = 1'b0;
    exp_t  const_exp;
    bit    last_accept;
    string cur_tag = "reset";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference: align by division, OR the discarded-bit flag into the LSB,
    // then add or subtract magnitudes with the sign rules of the datapath.
    function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                   input int unsigned diff, input bit se,
                                   input bit sa, input bit sb, input bit sym);
        longint unsigned ma, mb, x, r, pw;
        bit   st, eb, sub, sgn;
        exp_t e;
        ma = a * 8;
        mb = b * 8;
        x  = se ? ma : mb;
        if (diff >= XW) begin
            st = (x != 0);
            x  = 0;
        end else begin
            pw = 64'd1 << diff;
            st = (x % pw) != 0;
            x  = x / pw;
        end
        x = x | 64'(st);
        if (se) ma = x; else mb = x;
        eb  = sb ^ sym;
        sub = sa ^ eb;
        if (!sub) begin
            r = ma + mb; sgn = sa;
        end else if (ma >= mb) begin
            r = ma - mb; sgn = sa;
        end else begin
            r = mb - ma; sgn = eb;
        end
        if (sub && r == 0) sgn = 1'b0;
        e.out  = 25'(r / 8);
        e.grs  = 3'(r % 8);
        e.sign = sgn;
        e.zero = (r == 0);
        return e;
    endfunction

    task automatic check_beat();
        exp_t e;
        e = q.pop_front();
        check({cur_tag, ".out_rc"},  64'(out_rc),  64'(e.out));
        check({cur_tag, ".grs_rc"},  64'(grs_rc),  64'(e.grs));
        check({cur_tag, ".sign_rc"}, 64'(sign_rc), 64'(e.sign));
        check({cur_tag, ".zero_rc"}, 64'(zero_rc), 64'(e.zero));
        check({cur_tag, ".valid_la"}, 64'(ov_la), 64'd1);
        check({cur_tag, ".out_la"},  64'(out_la),  64'(e.out));
        check({cur_tag, ".grs_la"},  64'(grs_la),  64'(e.grs));
        check({cur_tag, ".sign_la"}, 64'(sign_la), 64'(e.sign));
        check({cur_tag, ".zero_la"}, 64'(zero_la), 64'(e.zero));
    endtask

    // Called at posedge+1: samples the handshake before the next edge, then
    // advances one clock.
    task automatic cycle();
        #1;
        last_accept = in_valid && ir_rc;
        if (last_accept)
            q.push_back(use_const ? const_exp
                        : model(64'(frac_a), 64'(frac_b), 32'(diff_exp),
                                sign_exp, sign_a, sign_b, symbol));
        if (ov_rc && out_ready) begin
            if (q.size() == 0) check({cur_tag, ".spurious_out"}, 64'(ov_rc), 64'd0);
            else check_beat();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        frac_a   = {1'b1, 23'($urandom)};
        frac_b   = {1'b1, 23'($urandom)};
        diff_exp = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(27, 255))
                                               : 8'($urandom_range(0, 28));
        sign_exp = 1'($urandom);
        sign_a   = 1'($urandom);
        sign_b   = 1'($urandom);
        symbol   = 1'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            frac_b   = frac_a;
            diff_exp = '0;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) cycle();
        check({cur_tag, ".drained"}, 64'(q.size()), 64'd0);
    endtask

    task automatic send_dir(input string tag, input logic [FW-1:0] a, input logic [FW-1:0] b,
                            input logic [EW-1:0] d, input logic se, input logic sa,
                            input logic sb, input logic sym, input exp_t e);
        bit acc;
        cur_tag  = tag;
        frac_a   = a;  frac_b = b;  diff_exp = d;  sign_exp = se;
        sign_a   = sa; sign_b = sb; symbol   = sym;
        const_exp = e;
        use_const = 1'b1;
        in_valid  = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            cycle();
            acc = last_accept;
        end
        in_valid  = 1'b0;
        use_const = 1'b0;
        check({tag, ".accepted"}, 64'(acc), 64'd1);
        drain(20);
    endtask

    initial begin
        int   n_acc, spurious;
        bit   seen;
        logic [FW:0] held;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        frac_a = '0; frac_b = '0; diff_exp = '0;
        sign_exp = 1'b0; sign_a = 1'b0; sign_b = 1'b0; symbol = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid_rc", 64'(ov_rc),   64'd0);
        check("reset.out_valid_la", 64'(ov_la),   64'd0);
        check("reset.out",          64'(out_rc),  64'd0);
        check("reset.grs",          64'(grs_rc),  64'd0);
        check("reset.sign",         64'(sign_rc), 64'd0);
        check("reset.zero",         64'(zero_rc), 64'd0);
        check("reset.in_ready_rc",  64'(ir_rc),   64'd1);
        check("reset.in_ready_la",  64'(ir_la),   64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases: expected values written out by hand.
        send_dir("add_d5",      24'd1500,     24'd37500, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd2671,     grs: 3'b111, sign: 1'b0, zero: 1'b0});
        send_dir("add_d5_neg",  24'd1500,     24'd37500, 8'd5,  1'b0, 1'b1, 1'b1, 1'b0,
                 '{out: 25'd2671,     grs: 3'b111, sign: 1'b1, zero: 1'b0});
        send_dir("add_carry",   24'd16777211, 24'd1500,  8'd5,  1'b0, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd16777257, grs: 3'b111, sign: 1'b0, zero: 1'b0});
        send_dir("sub_b_big",   24'd15000,    24'd36500, 8'd5,  1'b1, 1'b0, 1'b0, 1'b1,
                 '{out: 25'd36031,    grs: 3'b010, sign: 1'b1, zero: 1'b0});
        send_dir("add_d25",     24'd15000,    24'd36500, 8'd25, 1'b1, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd36500,    grs: 3'b001, sign: 1'b0, zero: 1'b0});
        send_dir("add_d27",     24'd15000,    24'd36500, 8'd27, 1'b1, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd36500,    grs: 3'b001, sign: 1'b0, zero: 1'b0});
        send_dir("add_d40",     24'd15000,    24'd36500, 8'd40, 1'b1, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd36500,    grs: 3'b001, sign: 1'b0, zero: 1'b0});
        send_dir("sticky_or",   24'd1000,  24'd16777215, 8'd26, 1'b0, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd1000,     grs: 3'b001, sign: 1'b0, zero: 1'b0});
        send_dir("add_d3",      24'd1000,     24'd9,     8'd3,  1'b0, 1'b0, 1'b0, 1'b0,
                 '{out: 25'd1001,     grs: 3'b001, sign: 1'b0, zero: 1'b0});
        send_dir("cancel",      24'd1000,     24'd1000,  8'd0,  1'b0, 1'b0, 1'b0, 1'b1,
                 '{out: 25'd0,        grs: 3'b000, sign: 1'b0, zero: 1'b1});

        // Stall: five beats offered with the output blocked.
        cur_tag   = "stall";
        out_ready = 1'b0;
        rand_inputs();
        in_valid = 1'b1;
        n_acc = 0; seen = 1'b0; held = '0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (last_accept) begin
                n_acc++;
                rand_inputs();
            end
            if (!seen && ov_rc) begin
                seen = 1'b1;
                held = out_rc;
            end
        end
        check("stall.accepted",    64'(n_acc), 64'd3);
        check("stall.in_ready_rc", 64'(ir_rc), 64'd0);
        check("stall.in_ready_la", 64'(ir_la), 64'd0);
        check("stall.out_valid",   64'(ov_rc), 64'd1);
        check("stall.out_held",    64'(out_rc), 64'(held));
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (n_acc < 5 || q.size() != 0); c++) begin
            cycle();
            if (last_accept) begin
                n_acc++;
                if (n_acc < 5) rand_inputs();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("stall.total_accepted", 64'(n_acc), 64'd5);
        check("stall.drained",        64'(q.size()), 64'd0);

        // Random traffic with random back-pressure.
        cur_tag = "random";
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(50);

        // Reset while beats are in flight.
        cur_tag   = "reset_mid";
        out_ready = 1'b1;
        rand_inputs();
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (last_accept) rand_inputs();
        end
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid.out_valid_rc", 64'(ov_rc), 64'd0);
        check("reset_mid.out_valid_la", 64'(ov_la), 64'd0);
        check("reset_mid.out",          64'(out_rc), 64'd0);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            if (ov_rc || ov_la) spurious++;
            cycle();
        end
        check("reset_mid.no_spurious", 64'(spurious), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
